// File: rtl/keycode_pkg.sv
// Shared types for the keycode event path: event record, FSM states, no-key code.
// Pure definitions; no logic, no latency, no backpressure.
// Imported by the FIFO and by the decoder top.
package keycode_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } kc_event_t;

  localparam int KC_EVENT_W = $bits(kc_event_t);

  typedef enum logic {
    KC_IDLE,
    KC_EMIT_PRESS
  } kc_state_t;

endpackage

// File: rtl/kc_event_fifo.sv
// In-order FIFO of kc_event_t entries with registered pointers and occupancy.
// Latency: a push is visible at the head one cycle after its edge (no bypass).
// Backpressure: a push while full is taken only when a pop happens on the same edge.
module kc_event_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [KC_EVENT_W-1:0] push_dat,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [KC_EVENT_W-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  kc_event_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the PIO keycode and turns committed level changes into queued press/release events.
// Latency: first event valid STABLE_CYCLES+2 edges after a change reaches keycode_in.
// Backpressure: ev_valid/ev_ready drain; events arriving while full are dropped and flag overflow.
module keycode_event_decoder
  import keycode_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_press,
  output logic [7:0] held_code,
  output logic       overflow
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [7:0]    kc_q;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  kc_state_t     state;
  kc_state_t     state_nxt;
  logic          commit;
  logic          push;
  kc_event_t     push_ev;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  kc_event_t     head_ev;

  assign commit = (cnt == CNT_MAX) && (cand != held_code) && (state == KC_IDLE);
  assign pop    = ev_valid && ev_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q      <= KEY_NONE;
      cand      <= KEY_NONE;
      cnt       <= '0;
      held_code <= KEY_NONE;
      overflow  <= 1'b0;
      state     <= KC_IDLE;
    end else begin
      kc_q <= keycode_in;
      if (kc_q != cand) begin
        cand <= kc_q;
        cnt  <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (commit) begin
        held_code <= cand;
      end
      state <= state_nxt;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // A key-to-key change is split: release the old key now, press the new one next cycle.
  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    push_ev.press = 1'b0;
    push_ev.code  = KEY_NONE;
    case (state)
      KC_IDLE: begin
        if (commit) begin
          push = 1'b1;
          if (held_code == KEY_NONE) begin
            push_ev.press = 1'b1;
            push_ev.code  = cand;
          end else begin
            push_ev.press = 1'b0;
            push_ev.code  = held_code;
            if (cand != KEY_NONE) begin
              state_nxt = KC_EMIT_PRESS;
            end
          end
        end
      end
      KC_EMIT_PRESS: begin
        // held_code already carries the new key committed on the previous edge.
        push          = 1'b1;
        push_ev.press = 1'b1;
        push_ev.code  = held_code;
        state_nxt     = KC_IDLE;
      end
      default: state_nxt = KC_IDLE;
    endcase
  end

  kc_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push),
    .push_dat (push_ev),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_ev)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = fifo_empty ? KEY_NONE : head_ev.code;
  assign ev_press = fifo_empty ? 1'b0 : head_ev.press;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Directed bench for keycode_event_decoder with default DEPTH=4, STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_keycode_event_decoder;

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_press;
  logic [7:0] held_code;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] log_ev  [$];
  int         log_cyc [$];

  keycode_event_decoder #(
    .DEPTH         (4),
    .STABLE_CYCLES (4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_in (keycode_in),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_press   (ev_press),
    .held_code  (held_code),
    .overflow   (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Record every handshake as {press, code} with its cycle number.
  always @(negedge Clk) begin
    if (ev_valid && ev_ready) begin
      log_ev.push_back({ev_press, ev_code});
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] code, input logic press);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_code"},  32'(ev_code),  32'(code));
    check({tag, "_press"}, 32'(ev_press), 32'(press));
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    keycode_in = 8'h00;
    ev_ready   = 1'b0;
    step(3);
    check("rst_valid",    32'(ev_valid),  32'd0);
    check("rst_code",     32'(ev_code),   32'd0);
    check("rst_press",    32'(ev_press),  32'd0);
    check("rst_held",     32'(held_code), 32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    Reset = 1'b0;
    step(2);

    // Single press then release, nothing drained.
    keycode_in = 8'h1A;
    step(5);
    check("t1_valid_early", 32'(ev_valid), 32'd0);
    step(1);
    check("t1_valid", 32'(ev_valid),  32'd1);
    check("t1_code",  32'(ev_code),   32'h1A);
    check("t1_press", 32'(ev_press),  32'd1);
    check("t1_held",  32'(held_code), 32'h1A);
    keycode_in = 8'h00;
    step(8);
    check("t1_held_rel", 32'(held_code), 32'h00);
    pop_check("t1_ev0", 8'h1A, 1'b1);
    pop_check("t1_ev1", 8'h1A, 1'b0);
    check("t1_empty",      32'(ev_valid), 32'd0);
    check("t1_empty_code", 32'(ev_code),  32'd0);

    // Two-cycle glitch must not commit.
    keycode_in = 8'h04;
    step(2);
    keycode_in = 8'h00;
    step(10);
    check("t2_held",  32'(held_code), 32'h00);
    check("t2_valid", 32'(ev_valid),  32'd0);

    // Direct key-to-key change drained live.
    log_ev.delete();
    log_cyc.delete();
    ev_ready   = 1'b1;
    keycode_in = 8'h1A;
    step(8);
    keycode_in = 8'h16;
    step(10);
    check("t3_held",  32'(held_code),    32'h16);
    check("t3_count", 32'(log_ev.size()), 32'd3);
    if (log_ev.size() >= 3) begin
      check("t3_ev0", 32'(log_ev[0]), 32'h11A);
      check("t3_ev1", 32'(log_ev[1]), 32'h01A);
      check("t3_ev2", 32'(log_ev[2]), 32'h116);
      check("t3_adjacent", 32'(log_cyc[2] - log_cyc[1]), 32'd1);
    end
    keycode_in = 8'h00;
    step(8);
    ev_ready = 1'b0;
    check("t3_drained", 32'(ev_valid), 32'd0);

    // Five events into a four-entry FIFO: the fifth is dropped.
    keycode_in = 8'h04; step(8);
    keycode_in = 8'h00; step(8);
    keycode_in = 8'h05; step(8);
    keycode_in = 8'h00; step(8);
    keycode_in = 8'h06; step(8);
    check("t4_overflow", 32'(overflow),  32'd1);
    check("t4_held",     32'(held_code), 32'h06);
    pop_check("t4_ev0", 8'h04, 1'b1);
    pop_check("t4_ev1", 8'h04, 1'b0);
    pop_check("t4_ev2", 8'h05, 1'b1);
    pop_check("t4_ev3", 8'h05, 1'b0);
    check("t4_empty",       32'(ev_valid), 32'd0);
    check("t4_ovf_sticky",  32'(overflow), 32'd1);
    keycode_in = 8'h00;
    do_reset();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    step(2);

    // Full FIFO with pop on the same edge as a new push.
    keycode_in = 8'h04; step(8);
    keycode_in = 8'h00; step(8);
    keycode_in = 8'h05; step(8);
    keycode_in = 8'h00; step(8);
    keycode_in = 8'h06;
    step(5);
    check("t5_full_valid", 32'(ev_valid), 32'd1);
    check("t5_pre_ovf",    32'(overflow), 32'd0);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check("t5_ovf",  32'(overflow),  32'd0);
    check("t5_held", 32'(held_code), 32'h06);
    pop_check("t5_ev0", 8'h04, 1'b0);
    pop_check("t5_ev1", 8'h05, 1'b1);
    pop_check("t5_ev2", 8'h05, 1'b0);
    pop_check("t5_ev3", 8'h06, 1'b1);
    check("t5_empty", 32'(ev_valid), 32'd0);
    keycode_in = 8'h00;
    do_reset();
    step(2);

    // Reset landing on the EMIT_PRESS cycle.
    keycode_in = 8'h1A;
    step(8);
    keycode_in = 8'h16;
    step(6);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check("t6_rst_valid", 32'(ev_valid),  32'd0);
    check("t6_rst_held",  32'(held_code), 32'h00);
    check("t6_rst_code",  32'(ev_code),   32'h00);
    step(5);
    check("t6_valid_early", 32'(ev_valid), 32'd0);
    step(1);
    check("t6_held", 32'(held_code), 32'h16);
    pop_check("t6_ev0", 8'h16, 1'b1);
    step(10);
    check("t6_single", 32'(ev_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
